// File: rtl/uart_echo_fifo.sv
// uart_echo_fifo
// Echo engine between a UART RX stream and a UART TX stream. Received words
// are buffered in a circular FIFO so RX is never back-pressured; a registered
// output stage feeds TX and optionally expands CR into CR,LF. Fill level,
// a saturating drop counter and the last transmitted word are exported for
// status display.
module uart_echo_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH_LOG2 = 4,
    parameter int OVF_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    input  logic                  mode_crlf,
    output logic [DEPTH_LOG2:0]   level,
    output logic [OVF_WIDTH-1:0]  overflow_count,
    output logic [DATA_WIDTH-1:0] last_tx
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   FULL_LEVEL = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DATA_WIDTH-1:0] CHAR_CR    = DATA_WIDTH'(8'h0D);
    localparam logic [DATA_WIDTH-1:0] CHAR_LF    = DATA_WIDTH'(8'h0A);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SEND    = 2'd1,
        ST_SEND_LF = 2'd2
    } state_t;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [OVF_WIDTH-1:0] sat_inc(input logic [OVF_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Storage and bookkeeping
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wptr;
    logic [DEPTH_LOG2-1:0] r_rptr;
    logic [DEPTH_LOG2:0]   r_level;
    logic [OVF_WIDTH-1:0]  r_ovf;
    logic                  r_rdy;

    // Output stage
    state_t                r_state;
    state_t                w_state_nxt;
    logic [DATA_WIDTH-1:0] r_tdata;
    logic                  r_tvalid;
    logic [DATA_WIDTH-1:0] r_last_tx;
    logic [DATA_WIDTH-1:0] w_tdata_nxt;
    logic                  w_tvalid_nxt;
    logic [DATA_WIDTH-1:0] w_last_tx_nxt;

    // Handshake decode
    logic                  w_accept;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_wr;
    logic                  w_drop;
    logic                  w_pop;
    logic [DATA_WIDTH-1:0] w_head;

    // Full/empty are judged on the pre-edge level, so a word arriving while
    // full is dropped even if the output stage pops on the same edge.
    assign w_accept = s_axis_tvalid & r_rdy;
    assign w_full   = (r_level == FULL_LEVEL);
    assign w_empty  = (r_level == '0);
    assign w_wr     = w_accept & ~w_full;
    assign w_drop   = w_accept & w_full;
    assign w_head   = r_mem[r_rptr];

    assign s_axis_tready  = r_rdy;
    assign m_axis_tdata   = r_tdata;
    assign m_axis_tvalid  = r_tvalid;
    assign level          = r_level;
    assign overflow_count = r_ovf;
    assign last_tx        = r_last_tx;

    // RX ready: low while in reset, high from the first edge after release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdy <= 1'b0;
        end else begin
            r_rdy <= 1'b1;
        end
    end

    // FIFO storage array; contents need no reset because level gates reads.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wptr] <= s_axis_tdata;
        end
    end

    // FIFO pointers and fill level; simultaneous write and pop cancel out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_wr, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // Saturating count of words dropped because the FIFO was full.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf <= '0;
        end else if (w_drop) begin
            r_ovf <= sat_inc(r_ovf);
        end
    end

    // Output state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, pop request and output-register updates for the TX stage.
    always_comb begin
        w_state_nxt   = r_state;
        w_pop         = 1'b0;
        w_tdata_nxt   = r_tdata;
        w_tvalid_nxt  = r_tvalid;
        w_last_tx_nxt = r_last_tx;
        case (r_state)
            ST_IDLE: begin
                w_tvalid_nxt = 1'b0;
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_tdata_nxt  = w_head;
                    w_tvalid_nxt = 1'b1;
                    w_state_nxt  = ST_SEND;
                end
            end
            ST_SEND: begin
                if (m_axis_tready) begin
                    w_last_tx_nxt = r_tdata;
                    // mode_crlf only matters at the moment the CR is taken.
                    if ((r_tdata == CHAR_CR) && mode_crlf) begin
                        w_tdata_nxt = CHAR_LF;
                        w_state_nxt = ST_SEND_LF;
                    end else if (!w_empty) begin
                        w_pop       = 1'b1;
                        w_tdata_nxt = w_head;
                    end else begin
                        w_tvalid_nxt = 1'b0;
                        w_state_nxt  = ST_IDLE;
                    end
                end
            end
            ST_SEND_LF: begin
                if (m_axis_tready) begin
                    w_last_tx_nxt = CHAR_LF;
                    if (!w_empty) begin
                        w_pop       = 1'b1;
                        w_tdata_nxt = w_head;
                        w_state_nxt = ST_SEND;
                    end else begin
                        w_tvalid_nxt = 1'b0;
                        w_state_nxt  = ST_IDLE;
                    end
                end
            end
            default: begin
                w_tvalid_nxt = 1'b0;
                w_state_nxt  = ST_IDLE;
            end
        endcase
    end

    // Registered TX outputs and last-transmitted capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tdata   <= '0;
            r_tvalid  <= 1'b0;
            r_last_tx <= '0;
        end else begin
            r_tdata   <= w_tdata_nxt;
            r_tvalid  <= w_tvalid_nxt;
            r_last_tx <= w_last_tx_nxt;
        end
    end

endmodule

// File: doc/uart_echo_fifo.md
Name: uart_echo_fifo

Overview:
Parametrised echo engine placed between a UART receiver's AXI-stream output and a UART transmitter's AXI-stream input. Received words are buffered in a FIFO so reception never stalls while the transmitter is busy. Optional CR→CRLF expansion is applied on the transmit side. The block also exports fill level, a saturating overflow count and the last transmitted word for status LEDs.

Parameters:
DATA_WIDTH, 8, width of stream data words
DEPTH_LOG2, 4, FIFO depth = 2**DEPTH_LOG2 entries (16 by default)
OVF_WIDTH, 16, width of the overflow counter

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
s_axis_tdata  in  DATA_WIDTH  received word from UART RX
s_axis_tvalid  in  1  received word valid
s_axis_tready  out  1  always 1 after reset; the block never back-pressures RX
m_axis_tdata  out  DATA_WIDTH  word to UART TX
m_axis_tvalid  out  1  output word valid
m_axis_tready  in  1  UART TX accepts word
mode_crlf  in  1  1 = expand CR (0x0D) to CR,LF on output
level  out  DEPTH_LOG2+1  number of words held in the FIFO; excludes the output register
overflow_count  out  OVF_WIDTH  number of words dropped because the FIFO was full; saturating
last_tx  out  DATA_WIDTH  last word accepted by TX (m_axis_tvalid & m_axis_tready)

Behaviour:
- Reset (async assert, sync-released logic):
  - FIFO empty; level=0, overflow_count=0, last_tx=0.
  - m_axis_tvalid=0, m_axis_tdata=0, s_axis_tready=0 during reset, then 1 from the first clock edge after reset release.
  - State=IDLE.
- Write side:
  - On an edge with s_axis_tvalid & s_axis_tready:
    - If level (pre-edge value) < 2**DEPTH_LOG2, the word is written.
    - Otherwise it is dropped and overflow_count increments, stopping at all-ones.
  - The full decision uses the pre-edge level. A word arriving while full is dropped even if a pop occurs in the same cycle.
- FIFO:
  - Circular buffer with DEPTH_LOG2-bit read/write pointers wrapping modulo depth.
  - level updates +1 on write only, -1 on pop only, unchanged on simultaneous write+pop.
- Output state machine (registered output stage):
  - IDLE:
    - m_axis_tvalid=0.
    - If FIFO non-empty: pop the head into m_axis_tdata, set m_axis_tvalid=1, go to SEND.
  - SEND:
    - Hold tdata/tvalid stable until m_axis_tready.
    - On handshake: last_tx<=tdata.
    - If tdata==0x0D (zero-extended to DATA_WIDTH) and mode_crlf==1 at that edge: tdata<=0x0A, stay valid, go to SEND_LF.
    - Else if FIFO non-empty: pop the next word into tdata the same edge (back-to-back, no bubble), stay in SEND.
    - Else: tvalid<=0, go to IDLE.
  - SEND_LF:
    - Hold 0x0A until m_axis_tready.
    - On handshake: last_tx<=0x0A, then the same pop-or-IDLE rule as SEND.
  - mode_crlf is sampled only at the CR handshake edge. Changing it at other times has no effect on words already in flight.
- Latency: a word accepted at edge k into an empty block with the output stage in IDLE is popped at edge k+1, so m_axis_tvalid is high during cycle k+1→k+2.
- Throughput: one output word per cycle while m_axis_tready=1 and the FIFO is non-empty.
- Ordering: strict FIFO order; LF always immediately follows its CR.
- Reset mid-operation: buffered data and any pending LF are discarded; outputs go to reset values immediately.

Test Plan:
- Single echo: after reset send 0x41, m_axis_tready=1 → m_axis_tvalid high 1 cycle later with 0x41; last_tx=0x41; level returns to 0; overflow_count=0.
- Overflow: m_axis_tready=0, send 0x00..0x13 (20 words, one per cycle) → stage holds 0x00, level=16, overflow_count=3. Then raise tready → output 0x00..0x10 in order, back-to-back, then tvalid=0.
- CRLF on: mode_crlf=1, send 0x61,0x0D,0x62 → output 0x61,0x0D,0x0A,0x62; with tready=1 there are no bubbles between them.
- CRLF off: mode_crlf=0, send 0x0D → output only 0x0D; no LF follows.
- Backpressure and simultaneous events:
  - Toggle m_axis_tready randomly while streaming 100 words below full → output sequence equals input sequence.
  - Fill to 16, then apply write and pop on the same edge → written word dropped, overflow_count +1.
  - Saturation: force OVF_WIDTH=2 and drop 5 words → overflow_count=3.
- Reset mid-operation: assert rst while level=5 and in SEND_LF → m_axis_tvalid=0, level=0, last_tx=0 immediately. After release, a new 0x55 echoes with no stale data or LF.
